// File: rtl/ocd_mem_reader.sv
// OCD memory read-back engine: walks a word range through the debugger
// read port and streams each captured word out over valid/ready.
module ocd_mem_reader #(
    parameter int ADDR_BITS      = 16,
    parameter int XLEN           = 32,
    parameter int CNT_BITS       = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [CNT_BITS-1:0]  req_count,
    output logic                 ocd_read_enable,
    output logic [ADDR_BITS-1:0] ocd_rw_addr,
    input  logic                 ocd_mem_enable_out,
    input  logic [XLEN-1:0]      ocd_mem_word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic [XLEN-1:0]      word_data,
    output logic [ADDR_BITS-1:0] word_addr,
    output logic                 word_last,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        FINISH
    } state_t;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE   = ADDR_BITS'(1);
    localparam logic [CNT_BITS-1:0]  CNT_ONE    = CNT_BITS'(1);
    localparam logic [15:0]          TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                state, state_n;
    logic [ADDR_BITS-1:0]  cur_addr, cur_addr_n;
    logic [CNT_BITS-1:0]   remaining, remaining_n;
    logic [15:0]           timer, timer_n;
    logic                  rd_en_n;
    logic [ADDR_BITS-1:0]  rw_addr_n;
    logic                  wv_n;
    logic [XLEN-1:0]       wd_n;
    logic [ADDR_BITS-1:0]  wa_n;
    logic                  wl_n;
    logic                  done_n;
    logic                  to_n;
    logic                  req_ready_n;
    logic                  busy_n;

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_n     = state;
        cur_addr_n  = cur_addr;
        remaining_n = remaining;
        timer_n     = timer;
        rd_en_n     = 1'b0;
        rw_addr_n   = ocd_rw_addr;
        wv_n        = word_valid;
        wd_n        = word_data;
        wa_n        = word_addr;
        wl_n        = word_last;
        done_n      = 1'b0;
        to_n        = timeout_err;
        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    cur_addr_n  = req_addr;
                    remaining_n = req_count;
                    to_n        = 1'b0;
                    if (req_count == '0) begin
                        state_n = FINISH;
                        done_n  = 1'b1;
                    end else begin
                        state_n   = ISSUE;
                        rd_en_n   = 1'b1;
                        rw_addr_n = req_addr;
                    end
                end
            end
            ISSUE: begin
                state_n = WAIT;
                timer_n = '0;
            end
            WAIT: begin
                if (ocd_mem_enable_out) begin
                    wv_n    = 1'b1;
                    wd_n    = ocd_mem_word_out;
                    wa_n    = cur_addr;
                    wl_n    = (remaining == CNT_ONE);
                    state_n = HOLD;
                end else if (timer == TIMER_LAST) begin
                    to_n    = 1'b1;
                    done_n  = 1'b1;
                    state_n = FINISH;
                end else begin
                    timer_n = timer + 16'd1;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    wv_n        = 1'b0;
                    remaining_n = remaining - CNT_ONE;
                    cur_addr_n  = cur_addr + ADDR_ONE;
                    if (word_last) begin
                        state_n = FINISH;
                        done_n  = 1'b1;
                    end else begin
                        state_n   = ISSUE;
                        rd_en_n   = 1'b1;
                        rw_addr_n = cur_addr + ADDR_ONE;
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        req_ready_n = (state_n == IDLE);
        busy_n      = (state_n != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state           <= IDLE;
            cur_addr        <= '0;
            remaining       <= '0;
            timer           <= '0;
            req_ready       <= 1'b1;
            ocd_read_enable <= 1'b0;
            ocd_rw_addr     <= '0;
            word_valid      <= 1'b0;
            word_data       <= '0;
            word_addr       <= '0;
            word_last       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            state           <= state_n;
            cur_addr        <= cur_addr_n;
            remaining       <= remaining_n;
            timer           <= timer_n;
            req_ready       <= req_ready_n;
            ocd_read_enable <= rd_en_n;
            ocd_rw_addr     <= rw_addr_n;
            word_valid      <= wv_n;
            word_data       <= wd_n;
            word_addr       <= wa_n;
            word_last       <= wl_n;
            busy            <= busy_n;
            done            <= done_n;
            timeout_err     <= to_n;
        end
    end

endmodule
